sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, giving backing-store depth of 2^MEM_AW 16-bit words.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the depth of the input synchronizer.
REQ-003 SHALL have port clk_100mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sram_a, input, 16 bits: word address from the external initiator.
REQ-006 SHALL have port sram_d_in, input, 16 bits: data-bus value as sampled from the pads.
REQ-007 SHALL have port sram_d_out, output, 16 bits: read data driven toward the pads.
REQ-008 SHALL have port sram_d_oe, output, 2 bits: pad drive enable; bit0 = D[7:0], bit1 = D[15:8].
REQ-009 SHALL have ports sram_ce, sram_oe, sram_we, sram_lb and sram_ub, inputs, 1 bit each, all active-low SRAM controls.
REQ-010 SHALL have ports wr_count and rd_count, outputs, 16 bits each: saturating transaction counters.

Function
REQ-011 SHALL pass all control, address and data inputs through a SYNC_STAGES-flop synchronizer before use; "s_" denotes the synchronized values below.
REQ-012 SHALL use address bits s_a[MEM_AW-1:0] only, so higher addresses alias.
REQ-013 SHALL run an FSM with states IDLE, READ and WRITE.
REQ-014 SHALL select the next state, in priority order: s_ce=1 -> IDLE; s_we=0 -> WRITE; s_oe=0 -> READ; otherwise IDLE.
REQ-015 SHALL, in WRITE, register s_a, s_d_in, s_lb and s_ub into a pending write every cycle.
REQ-016 SHALL commit the pending write to memory on the cycle WRITE is exited for any reason, writing only lanes whose enable was low.
REQ-017 SHALL count that commit as one write regardless of how many cycles WRITE lasted.
REQ-018 SHALL, on a commit with both lanes disabled, leave memory unchanged but still count the write.
REQ-019 SHALL, in READ, perform a synchronous memory read of s_a each cycle.
REQ-020 SHALL present read data on sram_d_out exactly 1 cycle after the FSM is in READ with that address.
REQ-021 SHALL give a total read latency, from pad change to valid sram_d_out, of SYNC_STAGES+2 clocks.
REQ-022 SHALL drive sram_d_oe[0] = READ & ~s_lb and sram_d_oe[1] = READ & ~s_ub, registered and aligned with sram_d_out.
REQ-023 SHALL drive sram_d_oe = 0 in IDLE and WRITE, so write takes priority over output enable when WE# and OE# are low together.
REQ-024 SHALL drive sram_d_out = 0 whenever the corresponding sram_d_oe bit is 0.
REQ-025 SHALL let read data follow address changes while in READ, with the same latency and no idle gap.
REQ-026 SHALL increment rd_count on each IDLE->READ or WRITE->READ transition, not per cycle.
REQ-027 SHALL hold wr_count and rd_count at 16'hFFFF once saturated.
REQ-028 SHALL deassert sram_d_oe within SYNC_STAGES+1 clocks of CE# or OE# rising at the pads.

Reset
REQ-029 SHALL, while rst=1, hold the FSM in IDLE, clear the synchronizers to 1 for controls and 0 for address/data, and drive sram_d_oe=0, sram_d_out=0, wr_count=0 and rd_count=0.
REQ-030 SHALL discard any pending write when rst asserts mid-WRITE, with memory unchanged.
REQ-031 SHALL NOT initialise memory contents on reset.

Structure
REQ-032 SHALL place the FSM state enum, the default MEM_AW and SYNC_STAGES, and the counter width in package sram_responder_pkg.
REQ-033 SHALL implement the backing store as one sub-module, sram_responder_mem: a single-port RAM with 2-bit byte write enable and 1-cycle registered read.

Verification
REQ-034 SHALL verify write then read: write 16'hA5C3 to 0x0010 with both lanes enabled, then OE# low at 0x0010 -> sram_d_out=16'hA5C3 and sram_d_oe=2'b11 exactly 4 clocks after the pads change; wr_count=1, rd_count=1.
REQ-035 SHALL verify byte lanes: preload 0x0020=16'h1234, write 16'hFFFF with UB#=1 and LB#=0 -> readback 16'h12FF; a read with LB#=1 -> sram_d_oe=2'b10, sram_d_out[7:0]=0.
REQ-036 SHALL verify WE/OE overlap: WE#, OE# and CE# all low for 10 clocks -> sram_d_oe stays 0 throughout, one write committed, wr_count increments by exactly 1.
REQ-037 SHALL verify aliasing and streaming reads: write 0x1005=16'hBEEF (MEM_AW=12), then read 0x0005, 0x0006, 0x0005 back-to-back, 3 clocks each -> 16'hBEEF, prior 0x0006 value, 16'hBEEF, each at latency 4; rd_count +1.
REQ-038 SHALL verify reset mid-write: rst pulsed while WE# is low at 0x0030 -> 0x0030 unchanged, wr_count=0, sram_d_oe=0 the cycle after rst.
REQ-039 SHALL verify saturation: force 65 540 read transactions -> rd_count holds 16'hFFFF.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared FSM type, defaults and counter helpers
// for the asynchronous SRAM target model.
package sram_responder_pkg;

   localparam int DEF_MEM_AW      = 12;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int CNT_W           = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      logic [CNT_W-1:0] r;
      r = v;
      if (~&v) r = v + 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// sram_responder_mem: single-port backing store, byte-lane write
// enables, registered read (read-first).
module sram_responder_mem #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we[0]) mem_q[addr][7:0]  <= wdata[7:0];
         if (we[1]) mem_q[addr][15:8] <= wdata[15:8];
         rdata <= mem_q[addr];
      end
   end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: async-SRAM target behind an input synchronizer,
// with pending-write commit, byte lanes and saturating counters.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int MEM_AW      = DEF_MEM_AW,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   input  logic [15:0] sram_a,
   input  logic [15:0] sram_d_in,
   output logic [15:0] sram_d_out,
   output logic [1:0]  sram_d_oe,
   input  logic        sram_ce,
   input  logic        sram_oe,
   input  logic        sram_we,
   input  logic        sram_lb,
   input  logic        sram_ub,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
);

   localparam int SW = 37;
   localparam logic [SW-1:0] SYNC_RST = {5'b11111, 32'h0};

   logic [SW-1:0] sync_q [SYNC_STAGES];

   logic        s_ce;
   logic        s_oe;
   logic        s_we;
   logic        s_lb;
   logic        s_ub;
   logic [15:0] s_a;
   logic [15:0] s_d_in;

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= SYNC_RST;
      end else begin
         sync_q[0] <= {sram_ce, sram_oe, sram_we,
                       sram_lb, sram_ub, sram_a, sram_d_in};
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign {s_ce, s_oe, s_we, s_lb, s_ub, s_a, s_d_in} =
      sync_q[SYNC_STAGES-1];

   // upper address bits alias onto the backing store
   logic [15-MEM_AW:0] s_a_hi_unused;
   assign s_a_hi_unused = s_a[15:MEM_AW];

   state_t state_q;
   state_t state_d;

   always_comb begin
      state_d = ST_IDLE;
      if (s_ce)
         state_d = ST_IDLE;
      else if (!s_we)
         state_d = ST_WRITE;
      else if (!s_oe)
         state_d = ST_READ;
      else
         state_d = ST_IDLE;
   end

   logic [MEM_AW-1:0] rd_a_q;
   logic              rd_lb_q;
   logic              rd_ub_q;
   logic [MEM_AW-1:0] pend_a_q;
   logic [15:0]       pend_d_q;
   logic              pend_lb_q;
   logic              pend_ub_q;
   logic [1:0]        oe_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [CNT_W-1:0]  rd_cnt_q;

   logic commit;
   logic rd_start;
   logic still_rd;

   assign commit   = !rst && (state_q == ST_WRITE)
                     && (state_d != ST_WRITE);
   assign rd_start = (state_d == ST_READ) && (state_q != ST_READ);
   assign still_rd = (state_q == ST_READ) && (state_d == ST_READ);

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_a_q    <= '0;
         rd_lb_q   <= 1'b1;
         rd_ub_q   <= 1'b1;
         pend_a_q  <= '0;
         pend_d_q  <= '0;
         pend_lb_q <= 1'b1;
         pend_ub_q <= 1'b1;
         oe_q      <= 2'b00;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_a_q  <= s_a[MEM_AW-1:0];
         rd_lb_q <= s_lb;
         rd_ub_q <= s_ub;
         if (state_d == ST_WRITE) begin
            pend_a_q  <= s_a[MEM_AW-1:0];
            pend_d_q  <= s_d_in;
            pend_lb_q <= s_lb;
            pend_ub_q <= s_ub;
         end
         // drive only while the live controls still ask for a read
         oe_q <= still_rd ? ~{rd_ub_q, rd_lb_q} : 2'b00;
         if (commit)   wr_cnt_q <= sat_inc(wr_cnt_q);
         if (rd_start) rd_cnt_q <= sat_inc(rd_cnt_q);
      end
   end

   logic              mem_en;
   logic [1:0]        mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       mem_rdata;

   assign mem_en   = commit || (state_q == ST_READ);
   assign mem_we   = commit ? ~{pend_ub_q, pend_lb_q} : 2'b00;
   assign mem_addr = commit ? pend_a_q : rd_a_q;

   sram_responder_mem #(
      .AW(MEM_AW)
   ) u_mem (
      .clk   (clk_100mhz),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (pend_d_q),
      .rdata (mem_rdata)
   );

   assign sram_d_oe  = oe_q;
   assign sram_d_out = mem_rdata & {{8{oe_q[1]}}, {8{oe_q[0]}}};
   assign wr_count   = wr_cnt_q;
   assign rd_count   = rd_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table plus hand sequences for
// overlap, streaming, reset mid-write and counter saturation.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sram_a;
   logic [15:0] sram_d_in;
   logic [15:0] sram_d_out;
   logic [1:0]  sram_d_oe;
   logic        sram_ce;
   logic        sram_oe;
   logic        sram_we;
   logic        sram_lb;
   logic        sram_ub;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   always #5 clk = ~clk;

   sram_responder #(
      .MEM_AW(12),
      .SYNC_STAGES(2)
   ) dut (
      .clk_100mhz (clk),
      .rst        (rst),
      .sram_a     (sram_a),
      .sram_d_in  (sram_d_in),
      .sram_d_out (sram_d_out),
      .sram_d_oe  (sram_d_oe),
      .sram_ce    (sram_ce),
      .sram_oe    (sram_oe),
      .sram_we    (sram_we),
      .sram_lb    (sram_lb),
      .sram_ub    (sram_ub),
      .wr_count   (wr_count),
      .rd_count   (rd_count)
   );

   typedef struct {
      bit          is_wr;
      logic [15:0] a;
      logic [15:0] d;
      logic        lb;
      logic        ub;
      logic [15:0] exp_d;
      logic [1:0]  exp_oe;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   wr_exp = 0;
   int   rd_exp = 0;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic idle_pads();
      sram_ce = 1'b1;
      sram_oe = 1'b1;
      sram_we = 1'b1;
      sram_lb = 1'b1;
      sram_ub = 1'b1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                           input logic lb, input logic ub);
      sram_ce = 1'b0;
      sram_we = 1'b0;
      sram_oe = 1'b1;
      sram_a = a;
      sram_d_in = d;
      sram_lb = lb;
      sram_ub = ub;
      step(3);
      idle_pads();
      step(5);
      wr_exp++;
   endtask

   task automatic do_read(input string name, input logic [15:0] a,
                          input logic lb, input logic ub,
                          input logic [15:0] exp_d,
                          input logic [1:0] exp_oe);
      sram_ce = 1'b0;
      sram_oe = 1'b0;
      sram_we = 1'b1;
      sram_a = a;
      sram_lb = lb;
      sram_ub = ub;
      step(3);
      chk({name, "_early_oe"}, {14'd0, sram_d_oe}, 16'd0);
      step(1);
      chk({name, "_data"}, sram_d_out, exp_d);
      chk({name, "_oe"}, {14'd0, sram_d_oe}, {14'd0, exp_oe});
      idle_pads();
      step(3);
      chk({name, "_oe_off"}, {14'd0, sram_d_oe}, 16'd0);
      step(2);
      rd_exp++;
   endtask

   task automatic rd_pulses(input int n);
      sram_ce = 1'b0;
      sram_we = 1'b1;
      for (int i = 0; i < n; i++) begin
         sram_oe = 1'b0;
         step(1);
         sram_oe = 1'b1;
         step(1);
      end
      step(4);
      idle_pads();
      step(2);
      rd_exp = rd_exp + n;
      if (rd_exp > 65535) rd_exp = 65535;
   endtask

   function automatic vec_t mk(bit w, logic [15:0] a, logic [15:0] d,
                               logic lb, logic ub, logic [15:0] ed,
                               logic [1:0] eo);
      vec_t v;
      v.is_wr = w;
      v.a = a;
      v.d = d;
      v.lb = lb;
      v.ub = ub;
      v.exp_d = ed;
      v.exp_oe = eo;
      return v;
   endfunction

   initial begin
      vecs.push_back(mk(1, 16'h0010, 16'hA5C3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 16'h0010, 0, 0, 0, 16'hA5C3, 2'b11));
      vecs.push_back(mk(1, 16'h0020, 16'h1234, 0, 0, 0, 0));
      vecs.push_back(mk(1, 16'h0020, 16'hFFFF, 0, 1, 0, 0));
      vecs.push_back(mk(0, 16'h0020, 0, 0, 0, 16'h12FF, 2'b11));
      vecs.push_back(mk(0, 16'h0020, 0, 1, 0, 16'h1200, 2'b10));
      vecs.push_back(mk(0, 16'h0020, 0, 0, 1, 16'h00FF, 2'b01));
      vecs.push_back(mk(0, 16'h0020, 0, 1, 1, 16'h0000, 2'b00));
      vecs.push_back(mk(1, 16'h0006, 16'h5A5A, 0, 0, 0, 0));
      vecs.push_back(mk(1, 16'h1005, 16'hBEEF, 0, 0, 0, 0));
      vecs.push_back(mk(0, 16'h0005, 0, 0, 0, 16'hBEEF, 2'b11));
      vecs.push_back(mk(1, 16'h0040, 16'h7777, 0, 0, 0, 0));
      vecs.push_back(mk(1, 16'h0040, 16'hCAFE, 1, 1, 0, 0));
      vecs.push_back(mk(0, 16'h0040, 0, 0, 0, 16'h7777, 2'b11));
      vecs.push_back(mk(1, 16'h0030, 16'h4444, 0, 0, 0, 0));

      rst = 1'b1;
      sram_a = '0;
      sram_d_in = '0;
      idle_pads();
      step(3);
      chk("rst_d_oe", {14'd0, sram_d_oe}, 16'd0);
      chk("rst_d_out", sram_d_out, 16'd0);
      chk("rst_wr_count", wr_count, 16'd0);
      chk("rst_rd_count", rd_count, 16'd0);
      rst = 1'b0;
      step(2);

      foreach (vecs[i]) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].a, vecs[i].d, vecs[i].lb, vecs[i].ub);
         else
            do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].lb,
                    vecs[i].ub, vecs[i].exp_d, vecs[i].exp_oe);
         chk($sformatf("vec%0d_wr_count", i), wr_count, 16'(wr_exp));
         chk($sformatf("vec%0d_rd_count", i), rd_count, 16'(rd_exp));
      end

      // WE#, OE#, CE# low together: write wins, no drive
      sram_ce = 1'b0;
      sram_we = 1'b0;
      sram_oe = 1'b0;
      sram_a = 16'h0050;
      sram_d_in = 16'h1357;
      sram_lb = 1'b0;
      sram_ub = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk($sformatf("ovl_oe_c%0d", i), {14'd0, sram_d_oe}, 16'd0);
      end
      idle_pads();
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk($sformatf("ovl_tail_oe_c%0d", i), {14'd0, sram_d_oe}, 16'd0);
      end
      wr_exp++;
      chk("ovl_wr_count", wr_count, 16'(wr_exp));
      chk("ovl_rd_count", rd_count, 16'(rd_exp));
      do_read("ovl_rb", 16'h0050, 0, 0, 16'h1357, 2'b11);

      // back-to-back reads with address changes every 3 clocks
      sram_ce = 1'b0;
      sram_oe = 1'b0;
      sram_a = 16'h0005;
      sram_lb = 1'b0;
      sram_ub = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         if (i == 4) chk("strm_0005", sram_d_out, 16'hBEEF);
         if (i == 7) chk("strm_0006", sram_d_out, 16'h5A5A);
         if (i == 10) chk("strm_0005b", sram_d_out, 16'hBEEF);
         if (i == 7) chk("strm_oe", {14'd0, sram_d_oe}, 16'h0003);
         if (i == 3) sram_a = 16'h0006;
         if (i == 6) sram_a = 16'h0005;
      end
      idle_pads();
      step(5);
      rd_exp++;
      chk("strm_rd_count", rd_count, 16'(rd_exp));

      // reset while a write is in progress
      sram_ce = 1'b0;
      sram_we = 1'b0;
      sram_oe = 1'b1;
      sram_a = 16'h0030;
      sram_d_in = 16'hDEAD;
      sram_lb = 1'b0;
      sram_ub = 1'b0;
      step(5);
      rst = 1'b1;
      step(1);
      chk("rstw_d_oe", {14'd0, sram_d_oe}, 16'd0);
      chk("rstw_wr_count", wr_count, 16'd0);
      idle_pads();
      step(2);
      rst = 1'b0;
      step(2);
      wr_exp = 0;
      rd_exp = 0;
      do_read("rstw_rb", 16'h0030, 0, 0, 16'h4444, 2'b11);
      chk("rstw_wr_count_after", wr_count, 16'd0);
      chk("rstw_rd_count_after", rd_count, 16'd1);

      // drive rd_count through saturation with 65540 transactions
      begin
         int n1;
         n1 = 65534 - rd_exp;
         rd_pulses(n1);
         chk("sat_fffe", rd_count, 16'hFFFE);
         rd_pulses(1);
         chk("sat_ffff", rd_count, 16'hFFFF);
         rd_pulses(65540 - n1 - 1);
         chk("sat_hold", rd_count, 16'hFFFF);
         chk("sat_wr_count", wr_count, 16'(wr_exp));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
